// File: rtl/cam_soc_led_pwm.sv
// Avalon-MM GPIO/LED output port with per-bit PWM dimming, atomic set/clear and shadowed duty.
// Latency: register write lands on out_port one edge later; zero-wait-state slave, no backpressure.
module cam_soc_led_pwm #(
    parameter int               WIDTH       = 8,
    parameter int               DUTY_W      = 8,
    parameter int               PRESC_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MODE   = 3'd1;
    localparam logic [2:0] ADDR_PRESC  = 3'd2;
    localparam logic [2:0] ADDR_DUTY   = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    logic [WIDTH-1:0]   data_reg;
    logic [WIDTH-1:0]   mode_reg;
    logic [PRESC_W-1:0] prescale_reg;
    logic [DUTY_W-1:0]  duty_reg;
    logic [DUTY_W-1:0]  duty_active;
    logic               duty_pending;
    logic [PRESC_W-1:0] presc_cnt;
    logic [DUTY_W-1:0]  pwm_cnt;

    logic             wr_en;
    logic             wr_data;
    logic             wr_mode;
    logic             wr_presc;
    logic             wr_duty;
    logic             wr_set;
    logic             wr_clr;
    logic             tick;
    logic             period_end;
    logic             pwm_on;
    logic [WIDTH-1:0] nxt;
    logic             unused_writedata;

    assign wr_en    = chipselect & ~write_n;
    assign wr_data  = wr_en && (address == ADDR_DATA);
    assign wr_mode  = wr_en && (address == ADDR_MODE);
    assign wr_presc = wr_en && (address == ADDR_PRESC);
    assign wr_duty  = wr_en && (address == ADDR_DUTY);
    assign wr_set   = wr_en && (address == ADDR_SET);
    assign wr_clr   = wr_en && (address == ADDR_CLR);

    // A PRESCALE write restarts the period, so it doubles as a duty load point.
    assign tick       = (presc_cnt == prescale_reg);
    assign period_end = wr_presc | (tick & (pwm_cnt == {DUTY_W{1'b1}}));
    assign pwm_on     = (pwm_cnt < duty_active);
    assign nxt        = data_reg & (~mode_reg | {WIDTH{pwm_on}});

    assign unused_writedata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg     <= RESET_VALUE;
            mode_reg     <= '0;
            prescale_reg <= '0;
            duty_reg     <= '0;
        end else begin
            if (wr_data)
                data_reg <= writedata[WIDTH-1:0];
            else if (wr_set)
                data_reg <= data_reg | writedata[WIDTH-1:0];
            else if (wr_clr)
                data_reg <= data_reg & ~writedata[WIDTH-1:0];
            if (wr_mode)
                mode_reg <= writedata[WIDTH-1:0];
            if (wr_presc)
                prescale_reg <= writedata[PRESC_W-1:0];
            if (wr_duty)
                duty_reg <= writedata[DUTY_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (wr_presc) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + 1'b1;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // Duty only changes at a period boundary so a running period is never cut short.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_active  <= '0;
            duty_pending <= 1'b0;
        end else if (wr_duty) begin
            if (period_end) begin
                duty_active  <= writedata[DUTY_W-1:0];
                duty_pending <= 1'b0;
            end else begin
                duty_pending <= 1'b1;
            end
        end else if (period_end) begin
            duty_active  <= duty_reg;
            duty_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_port <= RESET_VALUE;
        else
            out_port <= nxt;
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0]   = data_reg;
            ADDR_MODE:   readdata[WIDTH-1:0]   = mode_reg;
            ADDR_PRESC:  readdata[PRESC_W-1:0] = prescale_reg;
            ADDR_DUTY:   readdata[DUTY_W-1:0]  = duty_reg;
            ADDR_STATUS: begin
                readdata[DUTY_W-1:0] = pwm_cnt;
                readdata[31]         = duty_pending;
            end
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cam_soc_led_pwm.sv
// Directed bench for cam_soc_led_pwm (WIDTH=8, DUTY_W=8, PRESC_W=16, RESET_VALUE=A5).
// Reference model tracks elapsed cycles since the last counter restart and derives pwm state arithmetically.
module tb_cam_soc_led_pwm;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_chk  = 0;
    int n_fail = 0;

    cam_soc_led_pwm #(
        .WIDTH(8), .DUTY_W(8), .PRESC_W(16), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: m_t counts edges since the last restart (reset or PRESCALE write).
    logic [7:0]  m_data, m_mode, m_duty, m_act, m_out;
    logic [15:0] m_presc;
    logic        m_pend;
    int          m_t;

    logic m_wr, m_restart, m_bnd;
    int   t_next;
    assign m_wr      = chipselect && !write_n;
    assign m_restart = m_wr && (address == 3'd2);
    assign t_next    = m_restart ? 0 : m_t + 1;
    assign m_bnd     = m_restart || ((t_next % (256 * (int'(m_presc) + 1))) == 0);

    function automatic logic [7:0] m_pwm();
        int q;
        q = (m_t / (int'(m_presc) + 1)) % 256;
        return q[7:0];
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r[7:0]  = m_data;
            3'd1: r[7:0]  = m_mode;
            3'd2: r[15:0] = m_presc;
            3'd3: r[7:0]  = m_duty;
            3'd6: begin r[7:0] = m_pwm(); r[31] = m_pend; end
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data <= RV; m_mode <= '0; m_presc <= '0; m_duty <= '0;
            m_act <= '0; m_pend <= 1'b0; m_t <= 0; m_out <= RV;
        end else begin
            m_out <= m_data & (~m_mode | {8{m_pwm() < m_act}});
            m_t   <= t_next;
            if (m_wr) begin
                case (address)
                    3'd0: m_data  <= writedata[7:0];
                    3'd1: m_mode  <= writedata[7:0];
                    3'd2: m_presc <= writedata[15:0];
                    3'd3: m_duty  <= writedata[7:0];
                    3'd4: m_data  <= m_data | writedata[7:0];
                    3'd5: m_data  <= m_data & ~writedata[7:0];
                    default: ;
                endcase
            end
            if (m_wr && address == 3'd3) begin
                if (m_bnd) begin m_act <= writedata[7:0]; m_pend <= 1'b0; end
                else m_pend <= 1'b1;
            end else if (m_bnd) begin
                m_act <= m_duty; m_pend <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #2;
        write_n = 1'b1; chipselect = 1'b0;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(posedge clk);
            #2;
            if (out_port[0]) c++;
        end
    endtask

    int c;

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        fork
            forever begin
                @(posedge clk);
                #1;
                chk("model_out_port", 32'(out_port), 32'(m_out));
                chk("model_readdata", readdata, m_read(address));
            end
        join_none

        // 1: reset values, before any clock edge
        #1;
        chk("reset_out_no_clk", 32'(out_port), 32'h0000_00A5);
        rd("reset_mode", 3'd1, 32'h0);
        rd("reset_presc", 3'd2, 32'h0);
        rd("reset_duty", 3'd3, 32'h0);
        rd("reset_status", 3'd6, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 2: data write, atomic set/clear
        wr(3'd0, 32'h0000_000F);
        wr(3'd4, 32'hFFFF_FFF0);
        wr(3'd5, 32'h0000_0081);
        chk("out_before_latency", 32'(out_port), 32'h0000_00FF);
        @(posedge clk);
        #2;
        chk("out_after_clear", 32'(out_port), 32'h0000_007E);
        rd("data_readback", 3'd0, 32'h0000_007E);
        rd("outset_read_zero", 3'd4, 32'h0);

        // 3: duty 64 at prescale 0
        wr(3'd1, 32'h01);
        wr(3'd0, 32'h01);
        wr(3'd2, 32'h0);
        wr(3'd3, 32'd64);
        rd("status_pending", 3'd6, 32'h8000_0001);
        repeat (300) @(posedge clk);
        count_high(256, c);
        chk("duty64_high", 32'(c), 32'd64);
        @(negedge clk);
        address = 3'd6;
        #1;
        chk("status_pend_clear", {31'b0, readdata[31]}, 32'h0);

        // 4: double duty write mid-period
        wr(3'd2, 32'h0);
        count_high(99, c);
        chk("duty64_cur_period", 32'(c), 32'd64);
        wr(3'd3, 32'd200);
        wr(3'd3, 32'd10);
        rd("duty_read_last", 3'd3, 32'd10);
        count_high(155, c);
        chk("no_early_load", 32'(c), 32'd0);
        rd("duty_read_hold", 3'd3, 32'd10);
        count_high(256, c);
        chk("duty10_next_period", 32'(c), 32'd10);

        // 5: prescale 3, duty 128, then restart loads pending duty
        wr(3'd3, 32'd128);
        wr(3'd2, 32'd3);
        rd("presc_restart_status", 3'd6, 32'h0);
        count_high(10, c);
        chk("presc3_first10", 32'(c), 32'd10);
        rd("presc3_pwm_cnt", 3'd6, 32'h2);
        count_high(1024, c);
        chk("presc3_duty128", 32'(c), 32'd512);
        wr(3'd3, 32'd50);
        @(negedge clk);
        address = 3'd6;
        #1;
        chk("presc3_pending_set", {31'b0, readdata[31]}, 32'h1);
        wr(3'd2, 32'd3);
        rd("presc_write_clears", 3'd6, 32'h0);
        count_high(1024, c);
        chk("presc3_duty50", 32'(c), 32'd200);

        // 6: async reset mid-PWM, then duty 0 keeps pwm bit off
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_reset_out", 32'(out_port), 32'h0000_00A5);
        address = 3'd1;
        #1;
        chk("async_reset_mode", readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        address = 3'd6;
        #1;
        chk("release_status", readdata, 32'h0);
        rd("release_mode", 3'd1, 32'h0);
        wr(3'd1, 32'h01);
        wr(3'd0, 32'hFF);
        wr(3'd3, 32'h0);
        wr(3'd2, 32'h0);
        count_high(600, c);
        chk("duty0_never_on", 32'(c), 32'd0);
        chk("duty0_out_port", 32'(out_port), 32'h0000_00FE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
